// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS-subset control FSM (optional MC_MEM_WAIT_EN memory wait states)
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OpCode,
  input  logic [5:0] FunctField,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUCtrl,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BEQ       = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JR        = 4'd12,
    S_JAL       = 4'd13
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t cur, nxt;

  // Memory-access states may stall on mem_ready only in the wait-state build.
  logic mem_ok;
`ifdef MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  // Zero is consumed by the datapath's PCWriteCond gate, not here.
  logic unused_inputs;
  assign unused_inputs = ^{Zero, mem_ready};

  logic       d_pc_write, d_pc_write_cond, d_iord, d_mem_read, d_mem_write;
  logic       d_ir_write, d_reg_write, d_alu_src_a, d_instr_done, d_illegal;
  logic [1:0] d_reg_dst, d_mem_to_reg, d_alu_src_b, d_pc_source;
  logic [2:0] d_alu_ctrl;
  logic       funct_ok;
  logic [2:0] r_alu;

  // R-type funct field to ALU operation; unknown functs are flagged illegal.
  always_comb begin
    funct_ok = 1'b1;
    r_alu    = ALU_ADD;
    case (FunctField)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  // State register; reset parks the machine in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_FETCH;
    else        cur <= nxt;
  end

  // Next-state dispatch and per-state datapath controls.
  always_comb begin
    nxt             = cur;
    d_pc_write      = 1'b0;
    d_pc_write_cond = 1'b0;
    d_iord          = 1'b0;
    d_mem_read      = 1'b0;
    d_mem_write     = 1'b0;
    d_ir_write      = 1'b0;
    d_reg_write     = 1'b0;
    d_alu_src_a     = 1'b0;
    d_reg_dst       = 2'd0;
    d_mem_to_reg    = 2'd0;
    d_alu_src_b     = 2'd0;
    d_pc_source     = 2'd0;
    d_alu_ctrl      = 3'b000;
    d_instr_done    = 1'b0;
    d_illegal       = 1'b0;
    case (cur)
      S_FETCH: begin
        d_mem_read  = 1'b1;
        d_ir_write  = mem_ok;
        d_pc_write  = mem_ok;
        d_alu_src_b = 2'd1;
        d_alu_ctrl  = ALU_ADD;
        if (mem_ok) nxt = S_DECODE;
      end
      S_DECODE: begin
        d_alu_src_b = 2'd3;
        d_alu_ctrl  = ALU_ADD;
        case (OpCode)
          6'b000000: begin
            if (FunctField == 6'b001000) nxt = S_JR;
            else if (funct_ok)           nxt = S_R_EXEC;
            else begin
              nxt       = S_FETCH;
              d_illegal = 1'b1;
            end
          end
          6'b100011, 6'b101011: nxt = S_MEM_ADDR;
          6'b000100:            nxt = S_BEQ;
          6'b001000:            nxt = S_ADDI_EXEC;
          6'b000010:            nxt = S_JUMP;
          6'b000011:            nxt = S_JAL;
          default: begin
            nxt       = S_FETCH;
            d_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        d_alu_src_a = 1'b1;
        d_alu_src_b = 2'd2;
        d_alu_ctrl  = ALU_ADD;
        if (cur == S_ADDI_EXEC)        nxt = S_ADDI_WB;
        else if (OpCode == 6'b101011)  nxt = S_MEM_WR;
        else                           nxt = S_MEM_RD;
      end
      S_MEM_RD: begin
        d_mem_read = 1'b1;
        d_iord     = 1'b1;
        if (mem_ok) nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        d_reg_write  = 1'b1;
        d_mem_to_reg = 2'd1;
        d_instr_done = 1'b1;
        nxt          = S_FETCH;
      end
      S_MEM_WR: begin
        d_mem_write  = 1'b1;
        d_iord       = 1'b1;
        d_instr_done = mem_ok;
        if (mem_ok) nxt = S_FETCH;
      end
      S_R_EXEC: begin
        d_alu_src_a = 1'b1;
        d_alu_ctrl  = r_alu;
        nxt         = S_R_WB;
      end
      S_R_WB: begin
        d_reg_write  = 1'b1;
        d_reg_dst    = 2'd1;
        d_instr_done = 1'b1;
        nxt          = S_FETCH;
      end
      S_ADDI_WB: begin
        d_reg_write  = 1'b1;
        d_instr_done = 1'b1;
        nxt          = S_FETCH;
      end
      S_BEQ: begin
        d_alu_src_a     = 1'b1;
        d_alu_ctrl      = ALU_SUB;
        d_pc_write_cond = 1'b1;
        d_pc_source     = 2'd1;
        d_instr_done    = 1'b1;
        nxt             = S_FETCH;
      end
      S_JUMP: begin
        d_pc_write   = 1'b1;
        d_pc_source  = 2'd2;
        d_instr_done = 1'b1;
        nxt          = S_FETCH;
      end
      S_JR: begin
        d_pc_write   = 1'b1;
        d_pc_source  = 2'd3;
        d_instr_done = 1'b1;
        nxt          = S_FETCH;
      end
      S_JAL: begin
        d_pc_write   = 1'b1;
        d_pc_source  = 2'd2;
        d_reg_write  = 1'b1;
        d_reg_dst    = 2'd2;
        d_mem_to_reg = 2'd2;
        d_instr_done = 1'b1;
        nxt          = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Reset masks every output at once, so an aborted instruction leaves no strobe behind.
  assign PCWrite     = rst_n & d_pc_write;
  assign PCWriteCond = rst_n & d_pc_write_cond;
  assign IorD        = rst_n & d_iord;
  assign MemRead     = rst_n & d_mem_read;
  assign MemWrite    = rst_n & d_mem_write;
  assign IRWrite     = rst_n & d_ir_write;
  assign RegWrite    = rst_n & d_reg_write;
  assign ALUSrcA     = rst_n & d_alu_src_a;
  assign RegDst      = {2{rst_n}} & d_reg_dst;
  assign MemtoReg    = {2{rst_n}} & d_mem_to_reg;
  assign ALUSrcB     = {2{rst_n}} & d_alu_src_b;
  assign PCSource    = {2{rst_n}} & d_pc_source;
  assign ALUCtrl     = {3{rst_n}} & d_alu_ctrl;
  assign state       = {4{rst_n}} & cur;
  assign instr_done  = rst_n & d_instr_done;
  assign illegal_op  = rst_n & d_illegal;

endmodule
